// File: rtl/rv_alu_pkg.sv
// Shared RV32I execute-stage definitions: ALU operation codes, controller-side
// ALUOp constants and the registered execute-result record.
package rv_alu_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_RA_W   = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_BEQ  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_BNE  = 4'b1010,
        ALU_BLT  = 4'b1011,
        ALU_SLT  = 4'b1100,
        ALU_BGE  = 4'b1101,
        ALU_JAL  = 4'b1110,
        ALU_JALR = 4'b1111
    } alu_op_e;

    // Main-decoder to ALU-controller class codes.
    localparam logic [2:0] ALUOP_MEM    = 3'd0;
    localparam logic [2:0] ALUOP_BRANCH = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE  = 3'd2;
    localparam logic [2:0] ALUOP_ITYPE  = 3'd3;
    localparam logic [2:0] ALUOP_LUI    = 3'd4;
    localparam logic [2:0] ALUOP_JAL    = 3'd5;
    localparam logic [2:0] ALUOP_JALR   = 3'd6;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] result;
        logic                      redirect;
        logic [DEFAULT_DATA_W-1:0] target;
        logic [DEFAULT_RA_W-1:0]   rd;
        logic                      wen;
    } ex_result_t;

    function automatic logic is_branch(input alu_op_e op);
        return (op == ALU_BEQ) || (op == ALU_BNE) || (op == ALU_BLT) || (op == ALU_BGE);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I execute datapath: ALU result, branch decision,
// jump/branch target and link value.
module alu_core
    import rv_alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [3:0]        operation,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              redirect,
    output logic [DATA_W-1:0] target
);

    localparam int SH_W = $clog2(DATA_W);

    alu_op_e           op;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] pc_plus_4;
    logic [DATA_W-1:0] pc_plus_imm;
    logic [DATA_W-1:0] jalr_sum;
    logic              eq;
    logic              lt;
    logic              taken;

    assign op          = alu_op_e'(operation);
    assign shamt       = src_b[SH_W-1:0];
    assign sum         = src_a + src_b;
    assign diff        = src_a - src_b;
    assign pc_plus_4   = pc + DATA_W'(4);
    assign pc_plus_imm = pc + imm;
    assign jalr_sum    = src_a + imm;
    assign eq          = (src_a == src_b);
    assign lt          = ($signed(src_a) < $signed(src_b));

    // Only meaningful for the four branch codes; BGE is the complement of BLT.
    assign taken = (op == ALU_BEQ) ?  eq :
                   (op == ALU_BNE) ? !eq :
                   (op == ALU_BLT) ?  lt : !lt;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        result   = '0;
        redirect = 1'b0;
        target   = '0;
        unique case (op)
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_ADD:  result = sum;
            ALU_SUB:  result = diff;
            ALU_SLL:  result = src_a << shamt;
            ALU_SRL:  result = src_a >> shamt;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SRA:  result = $signed(src_a) >>> shamt;
            ALU_LUI:  result = src_b;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, lt};
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE: begin
                result   = {{(DATA_W-1){1'b0}}, taken};
                redirect = taken;
                target   = taken ? pc_plus_imm : '0;
            end
            ALU_JAL: begin
                result   = pc_plus_4;
                redirect = 1'b1;
                target   = pc_plus_imm;
            end
            ALU_JALR: begin
                result   = pc_plus_4;
                redirect = 1'b1;
                target   = jalr_sum & ~DATA_W'(1);
            end
        endcase
    end

endmodule

// File: rtl/ex_stage_alu.sv
// RV32I execute stage: alu_core result registered into a main output register
// backed by one skid entry, so in_ready comes straight from a flop.
module ex_stage_alu
    import rv_alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RA_W   = DEFAULT_RA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        operation,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] imm,
    input  logic [RA_W-1:0]   rd_in,
    input  logic              wen_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              redirect,
    output logic [DATA_W-1:0] target,
    output logic [RA_W-1:0]   rd_out,
    output logic              wen_out
);

    logic [DATA_W-1:0] core_result;
    logic              core_redirect;
    logic [DATA_W-1:0] core_target;

    ex_result_t new_entry;
    ex_result_t main_q;
    ex_result_t skid_q;
    logic       main_valid;
    logic       skid_valid;
    logic       in_fire;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .pc        (pc),
        .imm       (imm),
        .result    (core_result),
        .redirect  (core_redirect),
        .target    (core_target)
    );

    always_comb begin
        new_entry.result   = core_result;
        new_entry.redirect = core_redirect;
        new_entry.target   = core_target;
        new_entry.rd       = rd_in;
        new_entry.wen      = wen_in;
    end

    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: payload registers are reset too, because the outputs must read 0 straight out of reset.
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            // Main is empty or draining: the older skid entry always wins over new input.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire) begin
                    main_q <= new_entry;
                end
            end
        end else if (in_fire) begin
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid = main_valid;
    assign result    = main_q.result;
    assign redirect  = main_q.redirect;
    assign target    = main_q.target;
    assign rd_out    = main_q.rd;
    assign wen_out   = main_q.wen;

endmodule

// File: doc/ex_stage_alu.md
Name: ex_stage_alu

Overview:
- Execute stage of the RV32I pipeline. Sits directly downstream of the ALU controller.
- Consumes the 4-bit Operation code together with the operands registered from decode.
- Computes the ALU result, branch decision, jump target and link value.
- Presents results to the memory stage through a valid/ready registered output with a 2-entry skid buffer, so `in_ready` is a pure register output.

Parameters:
- DATA_W, 32, datapath width; shift amount taken from src_b[$clog2(DATA_W)-1:0].
- RA_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all stored and incoming entries (redirect from this stage or later)
- in_valid  in  1  upstream holds a valid op
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- operation  in  4  ALU Operation code (encoding below)
- src_a  in  DATA_W  rs1 value
- src_b  in  DATA_W  rs2 value or immediate (ALUSrc already applied)
- pc  in  DATA_W  instruction address
- imm  in  DATA_W  sign-extended branch/jump offset
- rd_in  in  RA_W  destination tag, passthrough
- wen_in  in  1  register-write enable, passthrough
- out_valid  out  1  result register holds a valid op
- out_ready  in  1  downstream accepts
- result  out  DATA_W  ALU result / link value
- redirect  out  1  taken branch or any jump
- target  out  DATA_W  next-PC when redirect=1, else 0
- rd_out  out  RA_W  passthrough tag
- wen_out  out  1  passthrough write enable

Behaviour:
- Operation encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0110 XOR, 0111 SRA
  - 1000 BEQ, 1001 LUI (result=src_b), 1010 BNE, 1011 BLT, 1100 SLT, 1101 BGE, 1110 JAL, 1111 JALR
  - All 16 codes are defined; no default/illegal case.
- Arithmetic:
  - ADD/SUB are modulo 2^DATA_W.
  - SLT and BLT/BGE compare signed.
  - SRA replicates src_a MSB.
  - Shifts use only the low $clog2(DATA_W) bits of src_b.
- Branches (1000, 1010, 1011, 1101):
  - result = {0…, taken}; wen_out passes through unchanged (decode drives 0).
  - redirect = taken; target = pc+imm when taken, else 0.
- JAL: result = pc+4; redirect=1; target = pc+imm.
- JALR: result = pc+4; redirect=1; target = (src_a+imm) with bit0 cleared.
- Other ops: redirect=0, target=0.
- Transfers:
  - Input transfer on in_valid&&in_ready.
  - Output transfer on out_valid&&out_ready.
- Latency and throughput: 1 cycle from input transfer to out_valid when the stage is empty; full throughput (1 op/cycle) while out_ready=1.
- Storage: main register (out_*) plus skid register. All computation happens before registering; the skid holds computed results.
- Skid/main update rules:
  - Main empty or draining: new op goes to main.
  - Main full, not draining, and input transfer: op goes to skid; in_ready drops next cycle.
  - Main drains while skid full: skid moves to main; skid clears; in_ready rises next cycle.
  - Ordering is strictly FIFO; an op never bypasses the skid entry.
- Outputs held stable while out_valid && !out_ready.
- flush=1:
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - Any input transfer in the flush cycle is discarded.
  - Output transfer in the same cycle still counts downstream.
  - flush overrides every other update.
- Reset (async assert, sync-deasserted by system):
  - out_valid=0, skid empty, in_ready=1.
  - result, target, rd_out, wen_out, redirect all 0.
  - Reset mid-stall discards both entries.

Decomposition:
- Shared package `rv_alu_pkg`:
  - `alu_op_e` enum (4-bit, codes above)
  - `ALUOP_*` 3-bit constants for the controller side
  - DATA_W default
  - `ex_result_t` struct: result, redirect, target, rd, wen
- One sub-module, `alu_core`: purely combinational; takes operation, src_a, src_b, pc, imm and produces `ex_result_t` fields.
- `ex_stage_alu` holds the skid/valid/flush logic and the two `ex_result_t` registers.

Test Plan:
1. Reset low, then high with in_valid=0 → out_valid=0, in_ready=1, result=0, redirect=0.
2. ADD a=0xFFFFFFFF b=1; SUB a=5 b=7; SRA a=0x80000000 b=0x24; SLT a=-1 b=1, back-to-back with out_ready=1 → results 0x0, 0xFFFFFFFE, 0xF8000000, 1 on consecutive cycles, one cycle after each input.
3. BEQ a=b=3 pc=0x100 imm=0x20 → result 1, redirect=1, target 0x120; BGE a=-2 b=1 → result 0, redirect=0, target 0; JALR a=0x203 imm=0x10 pc=0x40 → result 0x44, target 0x212.
4. Three ops A, B, C with out_ready=0 → A in main, B in skid, in_ready=0, C stalled upstream; release out_ready → outputs A, B, C in order, no loss or duplication.
5. Main and skid full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed input never appears.
6. Assert rst_n=0 asynchronously mid-stall → out_valid and all outputs 0 before the next clock edge.
